avalon_master_port: RTL and testbench



---
 rtl/codes.sv | 63 ++++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/avalon_master_port.sv | 145 ++++++++++++++
 tb/tb_avalon_master_port.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/codes.sv
// Shared encodings and lane helpers for the Avalon master port: access sizes, port states,
// byte-enable generation, store-data packing and load-data extraction.
package codes;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } port_state_t;

  function automatic logic is_misaligned(mem_size_t size, logic [1:0] off);
    return ((size == SIZE_HALF) && off[0]) ||
           ((size == SIZE_WORD) && (off != 2'b00)) ||
           (size == SIZE_RSVD);
  endfunction

  function automatic logic [3:0] lane_enable(mem_size_t size, logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return 4'b0011 << off;
      default:   return 4'b1111;
    endcase
  endfunction

  // Data is replicated across lanes; byteenable picks the live ones.
  function automatic logic [31:0] pack_wdata(mem_size_t size, logic [31:0] wdata, logic big);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return big ? {2{wdata[7:0], wdata[15:8]}} : {2{wdata[15:0]}};
      default:   return big ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]} : wdata;
    endcase
  endfunction

  function automatic logic [31:0] extract_rdata(mem_size_t size, logic [1:0] off, logic sgn,
                                                logic [31:0] rdata, logic big);
    logic [7:0]  b;
    logic [15:0] p;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    p = off[1] ? rdata[31:16] : rdata[15:0];
    h = big ? {p[7:0], p[15:8]} : p;
    case (size)
      SIZE_BYTE: res = {{24{sgn & b[7]}}, b};
      SIZE_HALF: res = {{16{sgn & h[15]}}, h};
      default:   res = big ? {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]} : rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr_i, wrapping to 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o,
  output logic          any_o
);

  always_comb begin
    grant_idx_o = '0;
    any_o       = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any_o && req_i[j] && (j >= int'(ptr_i))) begin
        any_o       = 1'b1;
        grant_idx_o = PW'(j);
      end
    end
    // Wrap-around pass for requests below the pointer.
    for (int j = 0; j < N; j++) begin
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        grant_idx_o = PW'(j);
      end
    end
    grant_o = any_o ? (N'(1) << grant_idx_o) : '0;
  end

endmodule

// File: rtl/avalon_master_port.sv
// Avalon-MM master shared by N_CHAN requesters: round-robin grant, waitrequest stall,
// byte-lane steering with optional big-endian swap, load extension and misalignment errors.
module avalon_master_port
  import codes::*;
#(
  parameter int N_CHAN     = 2,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CHAN-1:0]    req_valid_i,
  output logic [N_CHAN-1:0]    req_ready_o,
  input  logic [N_CHAN-1:0]    req_write_i,
  input  logic [2*N_CHAN-1:0]  req_size_i,
  input  logic [N_CHAN-1:0]    req_signed_i,
  input  logic [32*N_CHAN-1:0] req_addr_i,
  input  logic [32*N_CHAN-1:0] req_wdata_i,
  output logic [N_CHAN-1:0]    resp_valid_o,
  output logic                 resp_err_o,
  output logic [31:0]          resp_rdata_o,
  output logic                 busy_o,
  output logic [31:0]          address,
  output logic                 read,
  output logic                 write,
  input  logic                 waitrequest,
  output logic [31:0]          writedata,
  output logic [3:0]           byteenable,
  input  logic [31:0]          readdata
);

  localparam int PW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam bit BE = (BIG_ENDIAN != 0);

  port_state_t r_state, w_next_state;
  logic [PW-1:0] r_rr_ptr, r_cur_chan;
  logic          r_cur_write, r_cur_signed, r_cur_err;
  mem_size_t     r_cur_size;
  logic [1:0]    r_cur_off;
  logic [31:0]   r_rdata;

  logic [N_CHAN-1:0] w_grant;
  logic [PW-1:0]     w_idx;
  logic              w_any;
  logic              w_sel_write, w_sel_signed, w_misal;
  mem_size_t         w_sel_size;
  logic [31:0]       w_sel_addr, w_sel_wdata;

  rr_arbiter #(.N(N_CHAN), .PW(PW)) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (r_rr_ptr),
    .grant_o     (w_grant),
    .grant_idx_o (w_idx),
    .any_o       (w_any)
  );

  assign w_sel_write  = req_write_i[w_idx];
  assign w_sel_signed = req_signed_i[w_idx];
  assign w_sel_size   = mem_size_t'(req_size_i[2*int'(w_idx) +: 2]);
  assign w_sel_addr   = req_addr_i[32*int'(w_idx) +: 32];
  assign w_sel_wdata  = req_wdata_i[32*int'(w_idx) +: 32];
  assign w_misal      = is_misaligned(w_sel_size, w_sel_addr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Ready is gated by reset so a request is never acknowledged without being latched.
  always_comb begin
    w_next_state = r_state;
    req_ready_o  = '0;
    resp_valid_o = '0;
    case (r_state)
      IDLE: begin
        if (w_any && !reset) begin
          req_ready_o  = w_grant;
          w_next_state = w_misal ? RESP : ACCESS;
        end
      end
      ACCESS: if (!waitrequest) w_next_state = RESP;
      RESP: begin
        resp_valid_o = N_CHAN'(1) << r_cur_chan;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign busy_o       = (r_state != IDLE);
  assign resp_err_o   = (r_state == RESP) && r_cur_err;
  assign resp_rdata_o = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_cur_chan   <= '0;
      r_cur_write  <= 1'b0;
      r_cur_signed <= 1'b0;
      r_cur_err    <= 1'b0;
      r_cur_size   <= SIZE_BYTE;
      r_cur_off    <= 2'b00;
      r_rdata      <= '0;
      address      <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
      writedata    <= '0;
      byteenable   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_rr_ptr     <= (w_idx == PW'(N_CHAN - 1)) ? '0 : w_idx + 1'b1;
            r_cur_chan   <= w_idx;
            r_cur_write  <= w_sel_write;
            r_cur_signed <= w_sel_signed;
            r_cur_err    <= w_misal;
            r_cur_size   <= w_sel_size;
            r_cur_off    <= w_sel_addr[1:0];
            r_rdata      <= '0;
            if (!w_misal) begin
              address    <= {w_sel_addr[31:2], 2'b00};
              read       <= !w_sel_write;
              write      <= w_sel_write;
              byteenable <= lane_enable(w_sel_size, w_sel_addr[1:0]);
              writedata  <= w_sel_write ? pack_wdata(w_sel_size, w_sel_wdata, BE) : '0;
            end
          end
        end
        ACCESS: begin
          if (!waitrequest) begin
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
            if (!r_cur_write)
              r_rdata <= extract_rdata(r_cur_size, r_cur_off, r_cur_signed, readdata, BE);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_master_port.sv
// Directed bench for avalon_master_port (3 channels, big-endian).
module tb_avalon_master_port;
  localparam int NC = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   req_valid_i, req_ready_o, req_write_i, req_signed_i, resp_valid_o;
  logic [2*NC-1:0] req_size_i;
  logic [32*NC-1:0] req_addr_i, req_wdata_i;
  logic            resp_err_o, busy_o, read, write, waitrequest;
  logic [31:0]     resp_rdata_o, address, writedata, readdata;
  logic [3:0]      byteenable;
  int total = 0;
  int bad   = 0;

  avalon_master_port #(.N_CHAN(NC), .BIG_ENDIAN(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o),
    .resp_rdata_o(resp_rdata_o), .busy_o(busy_o), .address(address), .read(read),
    .write(write), .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int ch, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    req_write_i[ch]           = wr;
    req_size_i[2*ch +: 2]     = sz;
    req_signed_i[ch]          = sg;
    req_addr_i[32*ch +: 32]   = a;
    req_wdata_i[32*ch +: 32]  = wd;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    req_valid_i = 3'b001;
    repeat (2) @(negedge clk);
    total++; if (req_ready_o !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", req_ready_o); end
    total++; if ({read, write, address, byteenable, writedata} !== 70'd0) begin bad++;
      $display("FAIL reset_bus: rd=%b wr=%b addr=%h be=%b wd=%h want all 0", read, write, address, byteenable, writedata); end
    total++; if ({resp_valid_o, resp_err_o, resp_rdata_o, busy_o} !== 37'd0) begin bad++;
      $display("FAIL reset_resp: rv=%b err=%b rdata=%h busy=%b want all 0", resp_valid_o, resp_err_o, resp_rdata_o, busy_o); end
    req_valid_i = '0;
    reset = 1'b0;
  endtask

  task automatic test_word_load;
    @(negedge clk);
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    readdata = 32'h44332211; waitrequest = 1'b0; req_valid_i = 3'b001;
    #1;
    total++; if (req_ready_o !== 3'b001) begin bad++; $display("FAIL wl_ready: got %b want 001", req_ready_o); end
    total++; if ({read, write} !== 2'b00) begin bad++; $display("FAIL wl_bus_T: rd/wr=%b want 00", {read, write}); end
    @(negedge clk); req_valid_i = '0;
    total++; if ({read, write, address, byteenable} !== {1'b1, 1'b0, 32'h1000, 4'b1111}) begin bad++;
      $display("FAIL wl_bus: rd=%b wr=%b addr=%h be=%b want 1 0 1000 1111", read, write, address, byteenable); end
    total++; if (resp_valid_o !== 3'b000) begin bad++; $display("FAIL wl_early_resp: got %b want 000", resp_valid_o); end
    @(negedge clk);
    total++; if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {3'b001, 1'b0, 32'h11223344}) begin bad++;
      $display("FAIL wl_resp: rv=%b err=%b rdata=%h want 001 0 11223344", resp_valid_o, resp_err_o, resp_rdata_o); end
    total++; if (read !== 1'b0) begin bad++; $display("FAIL wl_read_drop: got %b want 0", read); end
    @(negedge clk);
    total++; if ({busy_o, resp_valid_o} !== 4'b0000) begin bad++; $display("FAIL wl_idle: busy=%b rv=%b want 0 000", busy_o, resp_valid_o); end
  endtask

  task automatic test_byte_wait;
    logic [31:0] exp_rd;
    for (int s = 1; s >= 0; s--) begin
      exp_rd = (s == 1) ? 32'hFFFFFF80 : 32'h00000080;
      @(negedge clk);
      set_req(1, 1'b0, 2'd0, s[0], 32'h2003, 32'h0);
      readdata = 32'h80123456; waitrequest = 1'b1; req_valid_i = 3'b010;
      #1;
      total++; if (req_ready_o !== 3'b010) begin bad++; $display("FAIL lb_ready s=%0d: got %b want 010", s, req_ready_o); end
      @(negedge clk); req_valid_i = '0;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) waitrequest = 1'b0;
        #1;
        total++; if ({read, write, address, byteenable} !== {1'b1, 1'b0, 32'h2000, 4'b1000}) begin bad++;
          $display("FAIL lb_hold s=%0d k=%0d: rd=%b wr=%b addr=%h be=%b want 1 0 2000 1000", s, k, read, write, address, byteenable); end
        total++; if (resp_valid_o !== 3'b000) begin bad++; $display("FAIL lb_early s=%0d k=%0d: rv=%b want 000", s, k, resp_valid_o); end
        @(negedge clk);
      end
      total++; if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {3'b010, 1'b0, exp_rd}) begin bad++;
        $display("FAIL lb_resp s=%0d: rv=%b err=%b rdata=%h want 010 0 %h", s, resp_valid_o, resp_err_o, resp_rdata_o, exp_rd); end
    end
  endtask

  task automatic test_half_store;
    @(negedge clk);
    set_req(0, 1'b1, 2'd1, 1'b0, 32'h3002, 32'h0000ABCD);
    waitrequest = 1'b0; req_valid_i = 3'b001;
    #1;
    total++; if (req_ready_o !== 3'b001) begin bad++; $display("FAIL sh_ready: got %b want 001", req_ready_o); end
    @(negedge clk); req_valid_i = '0;
    total++; if ({read, write, address, byteenable} !== {1'b0, 1'b1, 32'h3000, 4'b1100}) begin bad++;
      $display("FAIL sh_bus: rd=%b wr=%b addr=%h be=%b want 0 1 3000 1100", read, write, address, byteenable); end
    total++; if (writedata[31:16] !== 16'hCDAB) begin bad++; $display("FAIL sh_wdata: got %h want CDAB", writedata[31:16]); end
    @(negedge clk);
    total++; if ({resp_valid_o, resp_err_o, resp_rdata_o, write} !== {3'b001, 1'b0, 32'h0, 1'b0}) begin bad++;
      $display("FAIL sh_resp: rv=%b err=%b rdata=%h wr=%b want 001 0 0 0", resp_valid_o, resp_err_o, resp_rdata_o, write); end
  endtask

  task automatic test_misalign;
    @(negedge clk);
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h1002, 32'h0);
    req_valid_i = 3'b001;
    #1;
    total++; if (req_ready_o !== 3'b001) begin bad++; $display("FAIL mis_ready: got %b want 001", req_ready_o); end
    @(negedge clk); req_valid_i = '0;
    total++; if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {3'b001, 1'b1, 32'h0}) begin bad++;
      $display("FAIL mis_resp: rv=%b err=%b rdata=%h want 001 1 0", resp_valid_o, resp_err_o, resp_rdata_o); end
    total++; if ({read, write} !== 2'b00) begin bad++; $display("FAIL mis_bus_T1: rd/wr=%b want 00", {read, write}); end
    @(negedge clk);
    total++; if ({read, write, busy_o, resp_err_o} !== 4'b0000) begin bad++;
      $display("FAIL mis_after: rd=%b wr=%b busy=%b err=%b want 0 0 0 0", read, write, busy_o, resp_err_o); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_rdy [9];
    logic [2:0] exp_rv  [9];
    exp_rdy = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
    exp_rv  = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100};
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < NC; c++) set_req(c, 1'b0, 2'd2, 1'b0, 32'h100 * (c + 1), 32'h0);
    waitrequest = 1'b0; readdata = 32'h0; req_valid_i = 3'b111;
    for (int i = 0; i < 9; i++) begin
      #1;
      total++; if (req_ready_o !== exp_rdy[i]) begin bad++; $display("FAIL rr_ready cyc%0d: got %b want %b", i, req_ready_o, exp_rdy[i]); end
      total++; if (resp_valid_o !== exp_rv[i]) begin bad++; $display("FAIL rr_resp cyc%0d: got %b want %b", i, resp_valid_o, exp_rv[i]); end
      @(negedge clk);
    end
    req_valid_i = '0;
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    set_req(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    waitrequest = 1'b1; req_valid_i = 3'b010;
    #1;
    total++; if (req_ready_o !== 3'b010) begin bad++; $display("FAIL rm_ready: got %b want 010", req_ready_o); end
    @(negedge clk); req_valid_i = '0;
    @(negedge clk);
    total++; if ({read, busy_o} !== 2'b11) begin bad++; $display("FAIL rm_stall: rd=%b busy=%b want 1 1", read, busy_o); end
    reset = 1'b1;
    @(negedge clk);
    total++; if ({read, write, address, byteenable, busy_o, resp_valid_o} !== 42'd0) begin bad++;
      $display("FAIL rm_abort: rd=%b wr=%b addr=%h be=%b busy=%b rv=%b want all 0", read, write, address, byteenable, busy_o, resp_valid_o); end
    reset = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    total++; if ({resp_valid_o, busy_o} !== 4'b0000) begin bad++; $display("FAIL rm_no_resp: rv=%b busy=%b want 000 0", resp_valid_o, busy_o); end
    set_req(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    set_req(2, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    readdata = 32'hA1B2C3D4; req_valid_i = 3'b101;
    #1;
    total++; if (req_ready_o !== 3'b001) begin bad++; $display("FAIL rm_first_grant: got %b want 001", req_ready_o); end
    @(negedge clk); req_valid_i = '0;
    total++; if ({read, address} !== {1'b1, 32'h20}) begin bad++; $display("FAIL rm_bus: rd=%b addr=%h want 1 20", read, address); end
    @(negedge clk);
    total++; if ({resp_valid_o, resp_rdata_o} !== {3'b001, 32'hD4C3B2A1}) begin bad++;
      $display("FAIL rm_resp: rv=%b rdata=%h want 001 D4C3B2A1", resp_valid_o, resp_rdata_o); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req_valid_i = '0; req_write_i = '0; req_size_i = '0; req_signed_i = '0;
    req_addr_i = '0; req_wdata_i = '0; waitrequest = 1'b0; readdata = '0;
    test_reset();
    test_word_load();
    test_byte_wait();
    test_half_store();
    test_misalign();
    test_round_robin();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
